// File: rtl/neo_sample_reader_pkg.sv
// Shared types and width helpers for the NEO sample reader.
package neo_sample_reader_pkg;

  localparam int unsigned N_DEFAULT = 16;
  localparam int unsigned M_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_LATCH = 2'd2,
    ST_EMIT  = 2'd3
  } state_t;

  // Width of an exact x^2 - a*c result for N-bit signed samples.
  function automatic int unsigned psi_width(input int unsigned n);
    return 2 * n + 1;
  endfunction

  // Address/index width; one spare bit so M itself is representable.
  function automatic int unsigned addr_width(input int unsigned m);
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/neo_sample_reader_if.sv
// Memory read port plus result stream between the reader and its neighbours.
interface neo_sample_reader_if
  import neo_sample_reader_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned M = M_DEFAULT
);

  localparam int unsigned AW = addr_width(M);
  localparam int unsigned PW = psi_width(N);

  logic [AW-1:0]        raddr;
  logic signed [N-1:0]  rdata;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [PW-1:0] out_psi;
  logic [AW-1:0]        out_index;

  modport master (
    output raddr, out_valid, out_psi, out_index,
    input  rdata, out_ready
  );

  modport slave (
    input  raddr, out_valid, out_psi, out_index,
    output rdata, out_ready
  );

endinterface

// File: rtl/neo_sample_reader_core.sv
// Combinational NEO kernel: psi = b*b - a*c, exact at 2N+1 bits.
module neo_sample_reader_core
  import neo_sample_reader_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  localparam int unsigned PW = psi_width(N)
) (
  input  logic signed [N-1:0]  i_a,
  input  logic signed [N-1:0]  i_b,
  input  logic signed [N-1:0]  i_c,
  output logic signed [PW-1:0] o_psi_c
);

  logic signed [PW-1:0] w_a;
  logic signed [PW-1:0] w_b;
  logic signed [PW-1:0] w_c;

  // Sign-extend operands first so neither product nor difference can wrap.
  always_comb begin
    w_a     = PW'(i_a);
    w_b     = PW'(i_b);
    w_c     = PW'(i_c);
    o_psi_c = (w_b * w_b) - (w_a * w_c);
  end

endmodule

// File: rtl/neo_sample_reader.sv
// Read-side sequencer: walks the sample memory, keeps a 3-sample window
// and streams one NEO result per interior sample.
module neo_sample_reader
  import neo_sample_reader_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned M = M_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  neo_sample_reader_if.master io_bus,
  output logic                o_busy,
  output logic                o_done
);

  localparam int unsigned AW = addr_width(M);
  localparam int unsigned PW = psi_width(N);

  localparam logic [AW-1:0] K_ONE   = AW'(1);
  localparam logic [AW-1:0] K_FIRST = AW'(2);
  localparam logic [AW-1:0] K_LAST  = AW'(M - 1);

  state_t               r_state, w_state_nx;
  logic [AW-1:0]        r_k, w_k_nx;
  logic [AW-1:0]        r_raddr, w_raddr_nx;
  logic [AW-1:0]        r_index, w_index_nx;
  logic signed [N-1:0]  r_x0, w_x0_nx;
  logic signed [N-1:0]  r_x1, w_x1_nx;
  logic signed [N-1:0]  r_x2, w_x2_nx;
  logic signed [PW-1:0] r_psi, w_psi_nx;
  logic signed [PW-1:0] w_psi_core;
  logic                 r_valid, w_valid_nx;
  logic                 r_busy, w_busy_nx;
  logic                 r_done, w_done_nx;

  // Kernel sees the window as it will be after this cycle's shift.
  neo_sample_reader_core #(.N(N)) u_core (
    .i_a    (r_x1),
    .i_b    (r_x0),
    .i_c    (io_bus.rdata),
    .o_psi_c(w_psi_core)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_raddr <= '0;
      r_index <= '0;
      r_x0    <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
      r_psi   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_k     <= w_k_nx;
      r_raddr <= w_raddr_nx;
      r_index <= w_index_nx;
      r_x0    <= w_x0_nx;
      r_x1    <= w_x1_nx;
      r_x2    <= w_x2_nx;
      r_psi   <= w_psi_nx;
      r_valid <= w_valid_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

  // Next-state and next-output logic for the read/latch/emit walk.
  always_comb begin
    w_state_nx = r_state;
    w_k_nx     = r_k;
    w_raddr_nx = r_raddr;
    w_index_nx = r_index;
    w_x0_nx    = r_x0;
    w_x1_nx    = r_x1;
    w_x2_nx    = r_x2;
    w_psi_nx   = r_psi;
    w_valid_nx = r_valid;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_k_nx     = '0;
          w_raddr_nx = '0;
          w_busy_nx  = 1'b1;
          w_state_nx = ST_ADDR;
        end
      end
      ST_ADDR: begin
        w_state_nx = ST_LATCH;
      end
      ST_LATCH: begin
        w_x2_nx = r_x1;
        w_x1_nx = r_x0;
        w_x0_nx = io_bus.rdata;
        if (r_k < K_FIRST) begin
          w_k_nx     = r_k + K_ONE;
          w_raddr_nx = r_k + K_ONE;
          w_state_nx = ST_ADDR;
        end else begin
          w_psi_nx   = w_psi_core;
          w_index_nx = r_k - K_ONE;
          w_valid_nx = 1'b1;
          w_state_nx = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (io_bus.out_ready) begin
          w_valid_nx = 1'b0;
          if (r_k == K_LAST) begin
            w_done_nx  = 1'b1;
            w_busy_nx  = 1'b0;
            w_state_nx = ST_IDLE;
          end else begin
            w_k_nx     = r_k + K_ONE;
            w_raddr_nx = r_k + K_ONE;
            w_state_nx = ST_ADDR;
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  assign io_bus.raddr     = r_raddr;
  assign io_bus.out_valid = r_valid;
  assign io_bus.out_psi   = r_psi;
  assign io_bus.out_index = r_index;
  assign o_busy           = r_busy;
  assign o_done           = r_done;

endmodule
